// File: rtl/yd_ram_arbiter.sv
// yd_ram_arbiter: shares the single-port data RAM between the Yduck core load/store
// port (m0) and the debug/loader port (m1). One RAM access is issued per cycle and
// read data comes back one cycle later to whichever master issued the read.
// m1 may lock the RAM for bursts. A starvation guard breaks the lock after
// MAX_WAIT refused m0 cycles, so the core always makes forward progress.
// Build option: define ARB_RR_EN to arbitrate round-robin in IDLE.
// Without it, m0 has fixed priority over m1.
module yd_ram_arbiter #(
  parameter int DW       = 16,
  parameter int RAM_AW   = 7,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [RAM_AW-1:0] m0_addr,
  input  logic [DW-1:0]     m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DW-1:0]     m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [RAM_AW-1:0] m1_addr,
  input  logic [DW-1:0]     m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DW-1:0]     m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DW-1:0]     ram_wdata,
  input  logic [DW-1:0]     ram_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  typedef enum logic {IDLE, LOCK1} state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next;
  logic          rd_pend, rd_owner;
  logic          guard, rd_issue;
`ifdef ARB_RR_EN
  logic          rr_last;
`endif

  // A saturated wait counter while idle means the lock was just broken for m0
  assign guard    = (wait_cnt == MAX_CNT);
  assign rd_issue = ram_en & ~ram_we;

  // Grant selection, lock tracking and starvation counting
  always_comb begin
    m0_gnt        = 1'b0;
    m1_gnt        = 1'b0;
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE: begin
`ifdef ARB_RR_EN
        if (m0_req && (guard || !m1_req || rr_last))
          m0_gnt = 1'b1;
        else if (m1_req)
          m1_gnt = 1'b1;
`else
        if (m0_req)
          m0_gnt = 1'b1;
        else if (m1_req)
          m1_gnt = 1'b1;
`endif
        if (guard)
          wait_cnt_next = '0;
        if (m1_gnt && m1_lock) begin
          state_next    = LOCK1;
          wait_cnt_next = '0;
        end
      end
      LOCK1: begin
        m1_gnt = m1_req;
        if (m0_req && (wait_cnt != MAX_CNT))
          wait_cnt_next = wait_cnt + CW'(1);
        if (!m1_req || !m1_lock || (m0_req && (wait_cnt_next == MAX_CNT)))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (m0_gnt)
      wait_cnt_next = '0;
    if (rst) begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
    end
  end

  // State, counter and read-return pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      rd_pend  <= rd_issue;
      if (rd_issue)
        rd_owner <= m1_gnt;
    end
  end

`ifdef ARB_RR_EN
  // Remember which master won last so a tie goes to the other one
  always_ff @(posedge clk) begin
    if (rst)
      rr_last <= 1'b1;
    else if (m0_gnt)
      rr_last <= 1'b0;
    else if (m1_gnt)
      rr_last <= 1'b1;
  end
`endif

  assign ram_en    = m0_gnt | m1_gnt;
  assign ram_we    = m1_gnt ? m1_we : (m0_gnt & m0_we);
  assign ram_addr  = m1_gnt ? m1_addr : m0_addr;
  assign ram_wdata = m1_gnt ? m1_wdata : m0_wdata;

  assign m0_rvalid = rd_pend & ~rd_owner & ~rst;
  assign m1_rvalid = rd_pend & rd_owner & ~rst;
  assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_yd_ram_arbiter.sv
// tb_yd_ram_arbiter: directed scenarios followed by random traffic. A behavioural
// reference model of the arbitration rules predicts grants, the RAM bus and read
// returns every cycle. A simple RAM model answers the DUT's RAM port.
module tb_yd_ram_arbiter;

  localparam int DW       = 16;
  localparam int AW       = 7;
  localparam int MAX_WAIT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          mem_init;
  logic [DW-1:0] ram_mem [0:127];

  int checks = 0;
  int errors = 0;

  bit            ref_lock, ref_force, ref_rr, ref_pend, ref_owner;
  int            ref_refused;
  logic [DW-1:0] ref_mem [0:127];
  logic [DW-1:0] ref_pdata;
  bit            exp_g0, exp_g1;

  always #5 clk = ~clk;

  yd_ram_arbiter #(.DW(DW), .RAM_AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Single-port RAM with one-cycle read latency
  always_ff @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) ram_mem[i] <= '0;
      ram_rdata <= '0;
    end else if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, compare every output against the model, then advance the model
  task automatic applyStimulus(input bit r, input bit q0, input bit w0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0, input bit q1, input bit w1, input bit l1,
                               input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bit            rv0, rv1, g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;
    @(negedge clk);
    rst = r; m0_req = q0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = q1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
    #1;
    exp_g0 = 1'b0;
    exp_g1 = 1'b0;
    if (!r) begin
      if (ref_lock) exp_g1 = q1;
      else if (ref_force && q0) exp_g0 = 1'b1;
      else if (q0 && q1) begin
`ifdef ARB_RR_EN
        if (ref_rr) exp_g0 = 1'b1; else exp_g1 = 1'b1;
`else
        exp_g0 = 1'b1;
`endif
      end else begin
        exp_g0 = q0;
        exp_g1 = q1;
      end
    end
    g_we   = exp_g1 ? w1 : w0;
    g_addr = exp_g1 ? a1 : a0;
    g_data = exp_g1 ? d1 : d0;
    rv0 = !r && ref_pend && !ref_owner;
    rv1 = !r && ref_pend && ref_owner;
    checkOutput("m0_gnt", 32'(m0_gnt), 32'(exp_g0));
    checkOutput("m1_gnt", 32'(m1_gnt), 32'(exp_g1));
    checkOutput("ram_en", 32'(ram_en), 32'(exp_g0 | exp_g1));
    checkOutput("ram_addr", 32'(ram_addr), 32'(g_addr));
    if (exp_g0 | exp_g1) checkOutput("ram_we", 32'(ram_we), 32'(g_we));
    if ((exp_g0 | exp_g1) && g_we) checkOutput("ram_wdata", 32'(ram_wdata), 32'(g_data));
    checkOutput("m0_rvalid", 32'(m0_rvalid), 32'(rv0));
    checkOutput("m1_rvalid", 32'(m1_rvalid), 32'(rv1));
    checkOutput("m0_rdata", 32'(m0_rdata), rv0 ? 32'(ref_pdata) : 32'd0);
    checkOutput("m1_rdata", 32'(m1_rdata), rv1 ? 32'(ref_pdata) : 32'd0);
    if (r) begin
      ref_lock = 1'b0; ref_force = 1'b0; ref_refused = 0; ref_rr = 1'b1; ref_pend = 1'b0;
    end else begin
      ref_pend = 1'b0;
      if (exp_g0 | exp_g1) begin
        if (g_we) ref_mem[g_addr] = g_data;
        else begin
          ref_pend  = 1'b1;
          ref_owner = exp_g1;
          ref_pdata = ref_mem[g_addr];
        end
        ref_rr = exp_g1;
      end
      if (ref_lock) begin
        if (q0) ref_refused++;
        if (q0 && ref_refused >= MAX_WAIT) begin
          ref_lock  = 1'b0;
          ref_force = 1'b1;
        end else if (!q1 || !l1) ref_lock = 1'b0;
      end else begin
        if (ref_force || exp_g0) ref_refused = 0;
        ref_force = 1'b0;
        if (exp_g1 && l1) begin
          ref_lock    = 1'b1;
          ref_refused = 0;
        end
      end
    end
  endtask

  initial begin
    int run, ngr, m1w, n0, n1;
    bit drop, p0, p1, pw0, pw1, pl1, last_lock;
    logic [AW-1:0] pa0, pa1;
    logic [DW-1:0] pd0, pd1;

    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    ref_owner = 1'b0; ref_pdata = '0;
    rst = 1'b1; mem_init = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;

    // Reset: no grants, no read returns
    applyStimulus(1, 1, 0, 7'h01, 16'h0, 1, 0, 0, 7'h02, 16'h0);
    applyStimulus(1, 0, 0, 7'h00, 16'h0, 0, 0, 0, 7'h00, 16'h0);
    mem_init = 1'b0;

    // 1: m0 write then read back
    applyStimulus(0, 1, 1, 7'h05, 16'hFA1C, 0, 0, 0, 7'h00, 16'h0);
    checkOutput("t1_wr_gnt", 32'(m0_gnt), 32'd1);
    applyStimulus(0, 1, 0, 7'h05, 16'h0, 0, 0, 0, 7'h00, 16'h0);
    checkOutput("t1_rd_gnt", 32'(m0_gnt), 32'd1);
    applyStimulus(0, 0, 0, 7'h00, 16'h0, 0, 0, 0, 7'h00, 16'h0);
    checkOutput("t1_rvalid", 32'(m0_rvalid), 32'd1);
    checkOutput("t1_rdata", 32'(m0_rdata), 32'hFA1C);
    checkOutput("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);
    applyStimulus(0, 0, 0, 7'h00, 16'h0, 0, 0, 0, 7'h00, 16'h0);
    checkOutput("t1_pulse_end", 32'(m0_rvalid), 32'd0);

    // 2: both masters read every cycle for four cycles
    n0 = 0; n1 = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 1, 0, 7'h05, 16'h0, 1, 0, 0, 7'h06, 16'h0);
      if (m0_gnt) n0++;
      if (m1_gnt) n1++;
    end
`ifdef ARB_RR_EN
    checkOutput("t2_m0_grants", 32'(n0), 32'd2);
    checkOutput("t2_m1_grants", 32'(n1), 32'd2);
`else
    checkOutput("t2_m0_grants", 32'(n0), 32'd4);
    checkOutput("t2_m1_grants", 32'(n1), 32'd0);
`endif
    applyStimulus(0, 0, 0, 7'h00, 16'h0, 0, 0, 0, 7'h00, 16'h0);

    // 3: m1 locked write burst of 20 while m0 keeps asking
    applyStimulus(0, 0, 0, 7'h20, 16'h0, 1, 1, 1, 7'h10, 16'h3000);
    checkOutput("t3_lock_gnt", 32'(m1_gnt), 32'd1);
    run = 0; ngr = 0; m1w = 1; drop = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(0, !drop, 0, 7'h20, 16'h0, m1w < 20, 1, 1, 7'(7'h10 + 7'(m1w)), 16'(16'h3000 + 16'(m1w)));
      if (m1_gnt) m1w++;
      if (!drop && !m0_gnt) run++;
      if (m0_gnt) begin
        ngr++;
        if (ngr <= 2) checkOutput("t3_refused_run", 32'(run), 32'(MAX_WAIT));
        run = 0;
        drop = 1;
      end else drop = 0;
    end
    checkOutput("t3_m0_grants_seen", 32'(ngr >= 2), 32'd1);
    checkOutput("t3_m1_writes", 32'(m1w), 32'd20);

    // 4: top-address m1 read then m0 read, back to back
    applyStimulus(0, 0, 0, 7'h00, 16'h0, 1, 1, 0, 7'h7F, 16'hBEEF);
    applyStimulus(0, 1, 1, 7'h00, 16'h1234, 0, 0, 0, 7'h00, 16'h0);
    applyStimulus(0, 0, 0, 7'h00, 16'h0, 1, 0, 0, 7'h7F, 16'h0);
    applyStimulus(0, 1, 0, 7'h00, 16'h0, 0, 0, 0, 7'h00, 16'h0);
    checkOutput("t4_m1_rvalid", 32'(m1_rvalid), 32'd1);
    checkOutput("t4_m1_rdata", 32'(m1_rdata), 32'hBEEF);
    applyStimulus(0, 0, 0, 7'h00, 16'h0, 0, 0, 0, 7'h00, 16'h0);
    checkOutput("t4_m0_rvalid", 32'(m0_rvalid), 32'd1);
    checkOutput("t4_m0_rdata", 32'(m0_rdata), 32'h1234);

    // 5: reset right after an m0 read grant
    applyStimulus(0, 1, 0, 7'h05, 16'h0, 0, 0, 0, 7'h00, 16'h0);
    applyStimulus(1, 1, 0, 7'h05, 16'h0, 0, 0, 0, 7'h00, 16'h0);
    checkOutput("t5_rvalid_rst", 32'(m0_rvalid), 32'd0);
    checkOutput("t5_ram_en_rst", 32'(ram_en), 32'd0);
    applyStimulus(0, 0, 0, 7'h00, 16'h0, 1, 0, 0, 7'h05, 16'h0);
    checkOutput("t5_m1_first", 32'(m1_gnt), 32'd1);
    checkOutput("t5_rvalid_after", 32'(m0_rvalid), 32'd0);
    applyStimulus(0, 0, 0, 7'h00, 16'h0, 0, 0, 0, 7'h00, 16'h0);

    // 6: lock grant then m1 drops its request
    applyStimulus(0, 0, 0, 7'h00, 16'h0, 1, 1, 1, 7'h08, 16'h5A5A);
    applyStimulus(0, 1, 0, 7'h08, 16'h0, 0, 0, 0, 7'h00, 16'h0);
    checkOutput("t6_refused", 32'(m0_gnt), 32'd0);
    applyStimulus(0, 1, 0, 7'h08, 16'h0, 0, 0, 0, 7'h00, 16'h0);
    checkOutput("t6_granted", 32'(m0_gnt), 32'd1);

    // Random traffic: requests held until granted, occasional drops, locks and resets
    p0 = 0; p1 = 0; pw0 = 0; pw1 = 0; pl1 = 0; last_lock = 0;
    pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int c = 0; c < 1500; c++) begin
      bit r;
      if (!p0 && $urandom_range(0, 99) < 60) begin
        p0 = 1; pw0 = 1'($urandom_range(0, 1));
        pa0 = 7'($urandom_range(0, 15)); pd0 = 16'($urandom);
      end
      if (!p1 && $urandom_range(0, 99) < (last_lock ? 90 : 45)) begin
        p1 = 1; pw1 = 1'($urandom_range(0, 1)); pl1 = ($urandom_range(0, 99) < 40);
        pa1 = 7'($urandom_range(0, 15)); pd1 = 16'($urandom);
      end
      if (p0 && $urandom_range(0, 99) < 3) p0 = 0;
      if (p1 && $urandom_range(0, 99) < 3) p1 = 0;
      r = ($urandom_range(0, 199) == 0);
      applyStimulus(r, p0, pw0, pa0, pd0, p1, pw1, pl1, pa1, pd1);
      if (exp_g0) p0 = 0;
      if (exp_g1) begin p1 = 0; last_lock = pl1; end
    end

    applyStimulus(0, 0, 0, 7'h00, 16'h0, 0, 0, 0, 7'h00, 16'h0);
    applyStimulus(0, 0, 0, 7'h00, 16'h0, 0, 0, 0, 7'h00, 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
